scm_read_port_ctrl: RTL

- Read-side controller placed in front of the 2-read/2-write latch SCM register file.
- Arbitrates two independent requesters onto the SCM read ports. Each requester gets a req/gnt handshake, and read data comes back in a registered valid/ready output stage.
- Forwards same-cycle write data so that every granted read returns the most recent architectural value.
- Covers the window in which a write issued in cycle N is still being sampled and is not yet in the latch array.

---
 rtl/scm_read_port_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/scm_read_port_ctrl.sv
// Two independent SCM read ports: gnt is combinational, data returns one cycle after grant
// through a 1-entry valid/ready register. Stalls hold a snapshot; same-cycle writes are forwarded.
module scm_read_port_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  output logic                  gnt_a_o,
  output logic                  rvalid_a_o,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic                  rready_a_i,

  input  logic                  req_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  output logic                  gnt_b_o,
  output logic                  rvalid_b_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic                  rready_b_i,

  output logic [ADDR_WIDTH-1:0] scm_raddr_a_o,
  input  logic [DATA_WIDTH-1:0] scm_rdata_a_i,
  output logic [ADDR_WIDTH-1:0] scm_raddr_b_o,
  input  logic [DATA_WIDTH-1:0] scm_rdata_b_i,

  input  logic                  snp_we_a_i,
  input  logic [ADDR_WIDTH-1:0] snp_waddr_a_i,
  input  logic [DATA_WIDTH-1:0] snp_wdata_a_i,
  input  logic                  snp_we_b_i,
  input  logic [ADDR_WIDTH-1:0] snp_waddr_b_i,
  input  logic [DATA_WIDTH-1:0] snp_wdata_b_i
);

  logic [1:0]            w_req;
  logic [1:0]            w_rready;
  logic [1:0]            w_gnt;
  logic [ADDR_WIDTH-1:0] w_addr      [2];
  logic [DATA_WIDTH-1:0] w_scm_rdata [2];
  logic [DATA_WIDTH-1:0] w_cap       [2];

  logic [1:0]            r_vld;
  logic [DATA_WIDTH-1:0] r_dat       [2];

  assign w_req          = {req_b_i, req_a_i};
  assign w_rready       = {rready_b_i, rready_a_i};
  assign w_addr[0]      = addr_a_i;
  assign w_addr[1]      = addr_b_i;
  assign w_scm_rdata[0] = scm_rdata_a_i;
  assign w_scm_rdata[1] = scm_rdata_b_i;

  assign scm_raddr_a_o  = addr_a_i;
  assign scm_raddr_b_o  = addr_b_i;

  // Write port B wins on a shared address, matching the SCM's own write priority.
  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < 2; i++) begin
      w_cap[i] = w_scm_rdata[i];
      w_gnt[i] = w_req[i] & (~r_vld[i] | w_rready[i]);
      if (snp_we_b_i && (snp_waddr_b_i == w_addr[i])) begin
        w_cap[i] = snp_wdata_b_i;
      end else if (snp_we_a_i && (snp_waddr_a_i == w_addr[i])) begin
        w_cap[i] = snp_wdata_a_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_dat[0] <= '0;
      r_dat[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_gnt[i]) begin
          r_vld[i] <= 1'b1;
          r_dat[i] <= w_cap[i];
        end else if (w_rready[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  assign gnt_a_o    = w_gnt[0];
  assign gnt_b_o    = w_gnt[1];
  assign rvalid_a_o = r_vld[0];
  assign rvalid_b_o = r_vld[1];
  assign rdata_a_o  = r_dat[0];
  assign rdata_b_o  = r_dat[1];

endmodule
